// File: rtl/multicycle_adder.sv
// Chunk-serial adder/subtractor: CHUNK bits per cycle, done pulses the cycle after the last chunk (N+1 edges from start).
// No backpressure: start is taken whenever not busy, ignored during RUN; results hold until the next completion.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  input  logic             i_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_overflow,
  output logic             o_signed_ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_sum;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
  logic             r_sovf;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK:0]   w_chunk_sum;
  logic [WIDTH-1:0] w_work_nxt;
  logic             w_sovf;

  assign w_accept = i_start && (r_state != S_RUN);
  assign w_last   = (r_k == KW'(N - 1));

  // Operands shift right each cycle so the active chunk is always the low CHUNK bits;
  // b is stored already inverted for subtraction.
  assign w_chunk_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_work_nxt  = WIDTH'({w_chunk_sum[CHUNK-1:0], r_work} >> CHUNK);
  assign w_sovf      = (r_a_msb == r_b_msb) && (w_work_nxt[WIDTH-1] != r_a_msb);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = i_start ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = i_start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == S_RUN);
    o_done = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
      r_sovf  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_sub ? ~i_b : i_b;
      r_a_msb <= i_a[WIDTH-1];
      r_b_msb <= i_sub ? ~i_b[WIDTH-1] : i_b[WIDTH-1];
      r_carry <= i_sub ? ~i_carry_in : i_carry_in;
      r_k     <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_work  <= w_work_nxt;
      r_carry <= w_chunk_sum[CHUNK];
      r_k     <= r_k + KW'(1);
      if (w_last) begin
        r_sum  <= w_work_nxt;
        r_ovf  <= w_chunk_sum[CHUNK];
        r_sovf <= w_sovf;
      end
    end
  end

  assign o_sum        = r_sum;
  assign o_overflow   = r_ovf;
  assign o_signed_ovf = r_sovf;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: three instances (16/4, 8/8, 32/1) with a scoreboard of expected results.
module tb_multicycle_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
    logic        sovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st16, ci16, sb16, busy16, done16, ovf16, sovf16;
  logic [15:0] a16, b16, sum16;
  logic        st8, ci8, sb8, busy8, done8, ovf8, sovf8;
  logic [7:0]  a8, b8, sum8;
  logic        st32, ci32, sb32, busy32, done32, ovf32, sovf32;
  logic [31:0] a32, b32, sum32;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .i_clk(clk), .i_rst(rst), .i_start(st16), .i_a(a16), .i_b(b16), .i_carry_in(ci16), .i_sub(sb16),
    .o_busy(busy16), .o_done(done16), .o_sum(sum16), .o_overflow(ovf16), .o_signed_ovf(sovf16));
  multicycle_adder #(.WIDTH(8), .CHUNK(8)) u8 (
    .i_clk(clk), .i_rst(rst), .i_start(st8), .i_a(a8), .i_b(b8), .i_carry_in(ci8), .i_sub(sb8),
    .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_overflow(ovf8), .o_signed_ovf(sovf8));
  multicycle_adder #(.WIDTH(32), .CHUNK(1)) u32 (
    .i_clk(clk), .i_rst(rst), .i_start(st32), .i_a(a32), .i_b(b32), .i_carry_in(ci32), .i_sub(sb32),
    .o_busy(busy32), .o_done(done32), .o_sum(sum32), .o_overflow(ovf32), .o_signed_ovf(sovf32));

  int   tests = 0;
  int   fails = 0;
  exp_t q16[$];
  exp_t q8[$];
  exp_t q32[$];
  exp_t last16 = '0;
  exp_t last8  = '0;
  exp_t last32 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic o, input logic so);
    exp_t e;
    e.sum  = s;
    e.ovf  = o;
    e.sovf = so;
    return e;
  endfunction

  // Golden model in exact integer arithmetic: a +/- b +/- cin.
  function automatic exp_t golden(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub);
    longint ua, ub, ci, full, lim, sa, sb, sv;
    exp_t   e;
    ua   = longint'({32'h0, a});
    ub   = longint'({32'h0, b});
    ci   = cin ? 64'sd1 : 64'sd0;
    lim  = 64'sd1 <<< (w - 1);
    full = sub ? (ua - ub - ci) : (ua + ub + ci);
    e.sum  = 32'(full & ((64'sd1 <<< w) - 64'sd1));
    e.ovf  = sub ? (full >= 0) : (((full >>> w) & 64'sd1) != 0);
    sa   = a[w-1] ? (ua - (lim <<< 1)) : ua;
    sb   = b[w-1] ? (ub - (lim <<< 1)) : ub;
    sv   = sub ? (sa - sb - ci) : (sa + sb + ci);
    e.sovf = (sv >= lim) || (sv < -lim);
    return e;
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy16;
      1:       return busy8;
      default: return busy32;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done16;
      1:       return done8;
      default: return done32;
    endcase
  endfunction

  function automatic exp_t get_out(input int sel);
    case (sel)
      0:       return mk(32'(sum16), ovf16, sovf16);
      1:       return mk(32'(sum8), ovf8, sovf8);
      default: return mk(sum32, ovf32, sovf32);
    endcase
  endfunction

  function automatic exp_t get_last(input int sel);
    case (sel)
      0:       return last16;
      1:       return last8;
      default: return last32;
    endcase
  endfunction

  task automatic push(input int sel, input exp_t e);
    case (sel)
      0:       q16.push_back(e);
      1:       q8.push_back(e);
      default: q32.push_back(e);
    endcase
  endtask

  task automatic drive(input int sel, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb);
    case (sel)
      0:       begin st16 = st; a16 = a[15:0]; b16 = b[15:0]; ci16 = ci; sb16 = sb; end
      1:       begin st8 = st; a8 = a[7:0]; b8 = b[7:0]; ci8 = ci; sb8 = sb; end
      default: begin st32 = st; a32 = a; b32 = b; ci32 = ci; sb32 = sb; end
    endcase
  endtask

  task automatic check_pop(input string tag, input int sel);
    exp_t e;
    exp_t o;
    int   sz;
    sz = (sel == 0) ? q16.size() : (sel == 1) ? q8.size() : q32.size();
    chk({tag, "_sb_pending"}, 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      case (sel)
        0:       e = q16.pop_front();
        1:       e = q8.pop_front();
        default: e = q32.pop_front();
      endcase
      o = get_out(sel);
      chk({tag, "_sum"}, o.sum, e.sum);
      chk({tag, "_overflow"}, 32'(o.ovf), 32'(e.ovf));
      chk({tag, "_signed_ovf"}, 32'(o.sovf), 32'(e.sovf));
      case (sel)
        0:       last16 = e;
        1:       last8 = e;
        default: last32 = e;
      endcase
    end
  endtask

  // One clock; outputs are sampled 1ns after the edge and every done pulse is scored.
  task automatic tick();
    @(posedge clk);
    #1;
    if (done16) check_pop("w16", 0);
    if (done8)  check_pop("w8", 1);
    if (done32) check_pop("w32", 2);
  endtask

  task automatic check_hold(input string tag, input int sel);
    exp_t o;
    exp_t l;
    o = get_out(sel);
    l = get_last(sel);
    chk({tag, "_hold_sum"}, o.sum, l.sum);
    chk({tag, "_hold_ovf"}, {30'd0, o.ovf, o.sovf}, {30'd0, l.ovf, l.sovf});
  endtask

  // Full transaction with latency check; inputs are scrambled right after acceptance.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb, input exp_t e);
    int n;
    n = (sel == 0) ? 4 : (sel == 1) ? 1 : 32;
    push(sel, e);
    drive(sel, 1'b1, a, b, ci, sb);
    tick();
    drive(sel, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
    for (int i = 0; i < n; i++) begin
      chk("run_busy", 32'(get_busy(sel)), 32'd1);
      chk("run_no_done", 32'(get_done(sel)), 32'd0);
      check_hold("run", sel);
      tick();
    end
    chk("done_at_tn", 32'(get_done(sel)), 32'd1);
    chk("busy_low_at_done", 32'(get_busy(sel)), 32'd0);
    tick();
    chk("done_one_cycle", 32'(get_done(sel)), 32'd0);
    chk("idle_not_busy", 32'(get_busy(sel)), 32'd0);
  endtask

  task automatic rand_op(input int sel, input int w);
    logic [31:0] mask, a, b;
    logic        ci, sb;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    a    = $urandom & mask;
    b    = $urandom & mask;
    ci   = 1'($urandom);
    sb   = 1'($urandom);
    run_op(sel, a, b, ci, sb, golden(w, a, b, ci, sb));
  endtask

  initial begin
    logic [31:0] na, nb;
    exp_t        o;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    st16 = 1'b1;
    tick();
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_done", 32'(done16), 32'd0);
    chk("rst_sum", 32'(sum16), 32'd0);
    chk("rst_flags", {30'd0, ovf16, sovf16}, 32'd0);
    st16 = 1'b0;
    rst  = 1'b0;

    run_op(0, 32'h0000, 32'h0000, 1'b0, 1'b0, mk(32'h0000, 1'b0, 1'b0));
    run_op(0, 32'hF439, 32'h0024, 1'b1, 1'b0, mk(32'hF45E, 1'b0, 1'b0));
    run_op(0, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0, mk(32'hFFFF, 1'b1, 1'b0));
    run_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, mk(32'h8000, 1'b0, 1'b1));
    run_op(0, 32'h0005, 32'h0007, 1'b0, 1'b1, mk(32'hFFFE, 1'b0, 1'b0));
    run_op(0, 32'h0007, 32'h0005, 1'b1, 1'b1, mk(32'h0001, 1'b1, 1'b0));
    run_op(0, 32'h8000, 32'h0001, 1'b0, 1'b1, mk(32'h7FFF, 1'b1, 1'b1));

    // start held high: back-to-back operations through DONE, new operands relatched each time
    push(0, golden(16, 32'h1111, 32'h2222, 1'b0, 1'b0));
    drive(0, 1'b1, 32'h1111, 32'h2222, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("b2b_done", 32'(done16), 32'(i % 5 == 0));
      chk("b2b_busy", 32'(busy16), 32'(i % 5 != 0));
      if (i == 5 || i == 10) begin
        na = $urandom & 32'hFFFF;
        nb = $urandom & 32'hFFFF;
        push(0, golden(16, na, nb, 1'b1, 32'(i) == 32'd10));
        drive(0, 1'b1, na, nb, 1'b1, 32'(i) == 32'd10);
      end
    end
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("b2b_idle_done", 32'(done16), 32'd0);
    chk("b2b_sb_empty", 32'(q16.size()), 32'd0);

    // start pulsed mid-RUN with new operands is ignored
    push(0, mk(32'h3579, 1'b0, 1'b0));
    drive(0, 1'b1, 32'h1234, 32'h2345, 1'b0, 1'b0);
    tick();
    drive(0, 1'b0, 32'h1234, 32'h2345, 1'b0, 1'b0);
    tick();
    drive(0, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("ignore_no_early_done", 32'(done16), 32'd0);
    tick();
    chk("ignore_done_t4", 32'(done16), 32'd1);
    tick();
    chk("ignore_no_rerun", 32'(busy16), 32'd0);

    // reset after t2 abandons the operation
    run_op(0, 32'h0007, 32'h0005, 1'b1, 1'b1, mk(32'h0001, 1'b1, 1'b0));
    drive(0, 1'b1, 32'hABCD, 32'h1111, 1'b0, 1'b0);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    o = get_out(0);
    chk("midrst_sum", o.sum, 32'd0);
    chk("midrst_flags", {30'd0, o.ovf, o.sovf}, 32'd0);
    chk("midrst_busy", 32'(busy16), 32'd0);
    last16 = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_done", 32'(done16), 32'd0);
    end
    run_op(0, 32'h00FF, 32'h0F01, 1'b0, 1'b0, mk(32'h1000, 1'b0, 1'b0));

    for (int i = 0; i < 4; i++) rand_op(0, 16);
    for (int i = 0; i < 10; i++) rand_op(1, 8);
    for (int i = 0; i < 6; i++) rand_op(2, 32);

    chk("final_sb16_empty", 32'(q16.size()), 32'd0);
    chk("final_sb8_empty", 32'(q8.size()), 32'd0);
    chk("final_sb32_empty", 32'(q32.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per cycle; WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH are required; N = WIDTH/CHUNK.

Interface
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when the block is not busy.
REQ-006 a  input  WIDTH  operand A, latched on an accepted start.
REQ-007 b  input  WIDTH  operand B, latched on an accepted start.
REQ-008 carry_in  input  1  carry-in (add) or borrow-in (sub), latched on an accepted start.
REQ-009 sub  input  1  mode, latched on an accepted start; 0 = a+b+carry_in, 1 = a-b-carry_in.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 sum  output  WIDTH  registered result.
REQ-013 overflow  output  1  unsigned carry-out of the final chunk.
REQ-014 signed_ovf  output  1  two's-complement overflow of the result.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE or DONE with start=1 at an edge -> RUN; the edge SHALL latch a, b, carry_in and sub, clear chunk index k, and load the carry flop with carry_in (add) or ~carry_in (sub).
REQ-017 Each RUN edge SHALL add chunk k: a[k] + (sub ? ~b[k] : b[k]) + carry, store the CHUNK-bit result into the working register, update the carry flop, and increment k.
REQ-018 The edge that processes chunk N-1 SHALL move to DONE and copy the working register, final carry and signed overflow into sum, overflow and signed_ovf.
REQ-019 signed_ovf SHALL be 1 iff the MSB of both effective operands (a, and b or ~b) is equal and differs from sum MSB.
REQ-020 Latency: start sampled at edge t0 -> chunks processed at t1..tN -> done=1 for exactly the cycle after tN; busy=1 from after t0 until after tN.
REQ-021 DONE with start=0 SHALL return to IDLE at the next edge; DONE with start=1 SHALL enter RUN directly, so done is still a one-cycle pulse.
REQ-022 start while in RUN SHALL be ignored: no relatch and no effect on latency.
REQ-023 sum, overflow and signed_ovf SHALL change only at the completing edge (REQ-018) or on reset, and hold their value otherwise, including through the next RUN.
REQ-024 Input changes on a, b, carry_in or sub after acceptance SHALL NOT affect the in-flight result.
REQ-025 When N=1, RUN SHALL last one edge and produce the same combinational-equivalent result.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, overflow=0, signed_ovf=0, k=0 and clear the working and carry registers; this has priority over start.
REQ-027 Reset during RUN SHALL abandon the operation with no done pulse and no output update.

Verification
REQ-028 All scenarios use WIDTH=16, CHUNK=4 unless noted.
REQ-029 After reset, a=0000, b=0000, cin=0, sub=0 -> done 5th edge after start sample... precisely the cycle after t4; sum=0000, overflow=0, signed_ovf=0; busy high for t1..t4.
REQ-030 Add cases -> a=F439, b=0024, cin=1: sum=F45E, ovf=0; a=FFFF, b=FFFF, cin=1: sum=FFFF, ovf=1; a=7FFF, b=0001, cin=0: sum=8000, ovf=0, signed_ovf=1.
REQ-031 Subtract case -> sub=1, a=0005, b=0007, cin=0: sum=FFFE, overflow=0, signed_ovf=0; sub=1, a=0007, b=0005, cin=1: sum=0001, overflow=1.
REQ-032 Protocol -> start held high continuously: done pulses once every 5 cycles (back-to-back via DONE); start pulsed during RUN with new operands: result reflects the original operands only.
REQ-033 Reset after t2 of an operation -> no done pulse, and sum/overflow read 0 the next cycle; the next operation completes normally.
REQ-034 Parameter sweep -> WIDTH=8, CHUNK=8 and WIDTH=32, CHUNK=1: random operands, cin and sub are compared against a golden a±b±cin, with done at the cycle after tN (N=1 and N=32).
